// File: rtl/rr_disp_pkg.sv
// rr_disp_pkg
//   Shared definitions for the round-robin FIFO dispatcher.
//   Contents:
//     DEF_DATA_W / DEF_DEPTH  default word width and per-channel FIFO depth
//     NUM_CH                  number of downstream channels (fixed at 4)
//     ch_idx_t                2-bit channel index
//     next_ch()               mod-4 increment of a channel index
package rr_disp_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int NUM_CH     = 4;

    typedef logic [1:0] ch_idx_t;

    // Channel index after c; 3 wraps to 0 through the natural 2-bit overflow.
    function automatic ch_idx_t next_ch(input ch_idx_t c);
        return c + 2'd1;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo
//   Single-channel synchronous FIFO with a registered, one-cycle-latency read port.
//   Reset is synchronous and active-low.
//   Ports:
//     clk, rst_n  clock and synchronous active-low reset
//     wen         write request (ignored while full)
//     ren         read request
//     din         write data
//     dout        word popped last cycle, 0 otherwise (registered)
//     out_valid   dout holds a word popped last cycle (registered)
//     error       last-cycle read hit an empty FIFO (registered)
//     full        count == DEPTH (from registered count)
//     empty       count == 0 (from registered count)
module dispatch_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wen,
    input  logic              ren,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              out_valid,
    output logic              error,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_wr_s;
    logic              do_rd_s;

    // Status and qualified strobes come from the registered count only, so a
    // same-cycle read never frees room for a write and a same-cycle write is
    // never bypassed to a read.
    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign do_wr_s = wen && !full;
    assign do_rd_s = ren && !empty;

    // Storage array; not reset because entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (rst_n && do_wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy count; pointers wrap at DEPTH (a power of two).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered read port: data/valid/error are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout      <= {DATA_W{1'b0}};
            out_valid <= 1'b0;
            error     <= 1'b0;
        end else if (do_rd_s) begin
            dout      <= mem_r[rd_ptr_r];
            out_valid <= 1'b1;
            error     <= 1'b0;
        end else if (ren) begin
            dout      <= {DATA_W{1'b0}};
            out_valid <= 1'b0;
            error     <= 1'b1;
        end else begin
            dout      <= {DATA_W{1'b0}};
            out_valid <= 1'b0;
            error     <= 1'b0;
        end
    end

endmodule

// File: rtl/round_robin_fifo_dispatcher.sv
// round_robin_fifo_dispatcher
//   Splits one producer stream across four per-channel FIFOs in round-robin
//   order (0,1,2,3,0,...). Each channel is drained by its own read enable.
//   Reset is synchronous and active-low.
//   Configuration macro RR_DISP_SKIP_FULL_EN:
//     undefined - strict round-robin; a full target channel stalls the producer
//     defined   - work-conserving; the first non-full channel from sel onward
//                 takes the word and sel moves past it
//   Ports:
//     clk, rst_n  clock and synchronous active-low reset
//     in_valid    producer presents in_data
//     in_data     producer word
//     in_ready    combinational accept indication
//     ren         per-channel read request (bit i = channel i)
//     dout        channel i word at [i*DATA_W +: DATA_W], registered
//     out_valid   bit i: lane i holds a word popped last cycle
//     error       bit i: last-cycle ren[i] hit an empty FIFO
//     sel         current target channel pointer
module round_robin_fifo_dispatcher
    import rr_disp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [NUM_CH-1:0]        ren,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH-1:0]        error,
    output logic [1:0]               sel
);

    ch_idx_t           sel_r;
    ch_idx_t           target_s;
    logic              accept_s;
    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] empty_s;
    logic [NUM_CH-1:0] wen_s;

`ifdef RR_DISP_SKIP_FULL_EN
    ch_idx_t cand_s;
    logic    found_s;

    // Work-conserving target: first non-full channel scanning sel, sel+1, ...
    always_comb begin
        target_s = sel_r;
        found_s  = 1'b0;
        cand_s   = sel_r;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s = sel_r + ch_idx_t'(k);
            if (!found_s && !full_s[cand_s]) begin
                target_s = cand_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
        in_ready = found_s;
    end
`else
    // Strict round-robin target: always sel; a full target back-pressures.
    always_comb begin
        target_s = sel_r;
        in_ready = !full_s[sel_r];
    end
`endif

    assign accept_s = in_valid && in_ready;
    assign sel      = sel_r;

    // Target pointer: advances past the channel that took the word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_r <= 2'd0;
        end else if (accept_s) begin
            sel_r <= next_ch(target_s);
        end else begin
            sel_r <= sel_r;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wen_s[i] = accept_s && (target_s == ch_idx_t'(i));

        dispatch_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .wen       (wen_s[i]),
            .ren       (ren[i]),
            .din       (in_data),
            .dout      (dout[i*DATA_W +: DATA_W]),
            .out_valid (out_valid[i]),
            .error     (error[i]),
            .full      (full_s[i]),
            .empty     (empty_s[i])
        );
    end

endmodule
